// File: rtl/crc16_serial_checker.sv
// Serial CRC-16 frame checker: DATA_W payload bits then 16 CRC bits, MSB first.
// Optional saturating error counter output err_count: define CRC16_CHK_ERR_CNT_EN.
module crc16_serial_checker #(
  parameter int unsigned DATA_W = 32,
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sof,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              crc_ok,
  output logic              crc_err,
  output logic [DATA_W-1:0] data_out,
  output logic [15:0]       crc_calc,
  output logic [15:0]       rx_crc
`ifdef CRC16_CHK_ERR_CNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 16);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W + 15);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CRC,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [DATA_W-1:0]   payload_q, payload_d;
  logic [15:0]         rx_crc_q, rx_crc_d;
  logic                done_q, done_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [15:0]         calc_q, calc_d;
  logic                accept_sof;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  // A sof arriving in DONE is dropped; anywhere else it (re)starts a frame.
  assign accept_sof = bit_valid && sof && (state_q != S_DONE);
  assign busy       = (state_q == S_DATA) || (state_q == S_CRC);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    payload_d = payload_q;
    rx_crc_d  = rx_crc_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    err_d     = err_q;
    data_d    = data_q;
    calc_d    = calc_q;

    if (accept_sof) begin
      lfsr_d    = crc_step(INIT, bit_in);
      payload_d = DATA_W'(bit_in);
      rx_crc_d  = 16'h0000;
      cnt_d     = CNT_W'(1);
      ok_d      = 1'b0;
      err_d     = 1'b0;
      state_d   = (DATA_W == 1) ? S_CRC : S_DATA;
    end else begin
      case (state_q)
        S_DATA: begin
          if (bit_valid) begin
            lfsr_d    = crc_step(lfsr_q, bit_in);
            payload_d = (payload_q << 1) | DATA_W'(bit_in);
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_DATA) state_d = S_CRC;
          end
        end
        S_CRC: begin
          if (bit_valid) begin
            rx_crc_d = {rx_crc_q[14:0], bit_in};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) state_d = S_DONE;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          data_d  = payload_q;
          calc_d  = lfsr_q;
          ok_d    = (rx_crc_q == lfsr_q);
          err_d   = (rx_crc_q != lfsr_q);
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lfsr_q    <= INIT;
      payload_q <= '0;
      rx_crc_q  <= 16'h0000;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      calc_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      payload_q <= payload_d;
      rx_crc_q  <= rx_crc_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      data_q    <= data_d;
      calc_q    <= calc_d;
    end
  end

  assign frame_done = done_q;
  assign crc_ok     = ok_q;
  assign crc_err    = err_q;
  assign data_out   = data_q;
  assign crc_calc   = calc_q;
  assign rx_crc     = rx_crc_q;

`ifdef CRC16_CHK_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        count_err;

  // Aborted frames count as errors alongside failed verdicts.
  always_comb begin
    count_err = (accept_sof && busy) ||
                ((state_q == S_DONE) && (rx_crc_q != lfsr_q));
    err_cnt_d = err_cnt_q;
    if (count_err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 16'h0000;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule
